ped_signal_ctrl: RTL and testbench
==================================

PED_SIGNAL_CTRL -- requirements
Module: ped_signal_ctrl

Interface
REQ-001 Parameter WALK_TIME, default 8, number of cycles the steady walk phase lasts (legal range 1..31).
REQ-002 Parameter FLASH_TIME, default 6, number of cycles the flashing don't-walk phase lasts (legal range 1..31).
REQ-003 The block SHALL have these ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- veh_red  input  1  vehicle red lamp; synchronous to clk.
- veh_yellow  input  1  vehicle yellow lamp; synchronous to clk.
- veh_green  input  1  vehicle green lamp; synchronous to clk.
- btn  input  1  pedestrian push-button; asynchronous, level.
- walk  output  1  walk lamp.
- dont_walk  output  1  don't-walk lamp.
- req_pending  output  1  latched pedestrian request.
- countdown  output  5  remaining flash cycles, shown to pedestrians.
- aborted  output  1  one-cycle pulse when a crossing is cut short.

Function
REQ-004 red_only SHALL be veh_red & ~veh_yellow & ~veh_green; any other lamp combination, including illegal ones, counts as not red_only.
REQ-005 red_only_d SHALL be a register of red_only; red_start = red_only & ~red_only_d.
REQ-006 btn SHALL pass through a 2-flop synchronizer (s1, s2) plus an edge register s3; press = s2 & ~s3.
REQ-007 req_pending SHALL be set on the clk edge where press=1, so it rises on the 3rd rising edge at which btn is sampled high.
REQ-008 req_pending SHALL be cleared on WAIT_RED->WALK; if press coincides with that transition, set wins.
REQ-009 Presses in any state SHALL set req_pending; repeated presses while it is set have no further effect.
REQ-010 The FSM SHALL have states IDLE, WAIT_RED, WALK, FLASH, CLEAR, plus a 5-bit down-counter cnt.
REQ-011 IDLE -> WAIT_RED when req_pending=1.
REQ-012 WAIT_RED -> WALK when red_start=1, with cnt<=WALK_TIME-1. A request raised mid-red SHALL wait for the next red_start.
REQ-013 WALK -> FLASH when cnt=0 and red_only=1, with cnt<=FLASH_TIME-1; otherwise cnt decrements.
REQ-014 FLASH -> CLEAR when cnt=0 and red_only=1; otherwise cnt decrements.
REQ-015 Abort: in WALK or FLASH, if red_only=0 the FSM SHALL go to CLEAR, and aborted SHALL be 1 for exactly the next cycle. Abort has priority over cnt expiry.
REQ-016 CLEAR -> IDLE when red_only=0, which limits service to at most one crossing per red phase.
REQ-017 WALK SHALL last exactly WALK_TIME cycles and FLASH exactly FLASH_TIME cycles, unless aborted.
REQ-018 Output decode:
- walk=1 only in WALK.
- dont_walk=1 in IDLE, WAIT_RED and CLEAR, and 0 in WALK.
- In FLASH, dont_walk=1 on the first FLASH cycle and toggles every cycle after that.
REQ-019 countdown SHALL be cnt+1 in FLASH and 0 in all other states.
REQ-020 walk and dont_walk SHALL never both be 1.
REQ-021 walk SHALL never be 1 in a cycle where red_only was 0 on the previous edge.

Reset
REQ-022 On reset assertion, immediately and regardless of clk:
- state = IDLE; cnt, s1, s2, s3, red_only_d = 0.
- walk = 0, dont_walk = 1, req_pending = 0, countdown = 0, aborted = 0.
REQ-023 Reset mid-crossing SHALL discard any pending request; after release, a new press is required.

Verification
REQ-024 Basic crossing (defaults):
- Stimulus: btn pressed during green; red_only rises at T and holds 21 cycles.
- Response: walk=1 for cycles T+1..T+8; FLASH for T+9..T+14 with countdown 6,5,4,3,2,1 and dont_walk 1,0,1,0,1,0; CLEAR (dont_walk=1) from T+15.
REQ-025 Late request:
- Stimulus: btn pressed 5 cycles after red_only rises.
- Response: no walk in that red; req_pending stays 1; crossing starts on the next red_start.
REQ-026 Abort:
- Stimulus: red_only drops 3 cycles into WALK.
- Response: walk=0 and dont_walk=1 the next cycle; aborted pulses once; state CLEAR then IDLE.
REQ-027 Synchronizer and glitch:
- Stimulus: btn high for 1 clk period, aligned to the sampling edge.
- Response: req_pending=1 three edges later; no double request.
- Stimulus: btn high for less than 1 clk period with no sampling edge.
- Response: no request.
REQ-028 Red-yellow phase:
- Stimulus: veh_red=veh_yellow=1 while a request is pending.
- Response: walk stays 0 until red-only.
REQ-029 Async reset:
- Stimulus: reset asserted mid-FLASH between clock edges.
- Response: walk=0, dont_walk=1, countdown=0, req_pending=0 immediately; no walk after release without a new press.

Source files
------------

// File: rtl/ped_signal_ctrl.sv
// Pedestrian crossing controller: grants one walk/flash crossing per vehicle red phase
// when a synchronized push-button request is pending, aborting if red is lost early.
module ped_signal_ctrl #(
   parameter int unsigned WALK_TIME  = 8,
   parameter int unsigned FLASH_TIME = 6
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       veh_red,
   input  logic       veh_yellow,
   input  logic       veh_green,
   input  logic       btn,
   output logic       walk,
   output logic       dont_walk,
   output logic       req_pending,
   output logic [4:0] countdown,
   output logic       aborted
);

   typedef enum logic [2:0] {
      StIdle,
      StWaitRed,
      StWalk,
      StFlash,
      StClear
   } state_e;

   localparam logic [4:0] WalkLoad  = 5'(WALK_TIME - 1);
   localparam logic [4:0] FlashLoad = 5'(FLASH_TIME - 1);

   state_e     state_q, state_d;
   logic [4:0] cnt_q, cnt_d;
   logic       flash_on_q, flash_on_d;
   logic       aborted_q, aborted_d;
   logic       req_q, req_d;
   logic       red_only_q;
   logic       s1_q, s2_q, s3_q;

   logic       red_only;
   logic       red_start;
   logic       press;
   logic       req_clear;

   // Illegal lamp combinations are treated as "not safe to cross".
   assign red_only  = veh_red & ~veh_yellow & ~veh_green;
   assign red_start = red_only & ~red_only_q;
   assign press     = s2_q & ~s3_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q       <= 1'b0;
         s2_q       <= 1'b0;
         s3_q       <= 1'b0;
         red_only_q <= 1'b0;
      end else begin
         s1_q       <= btn;
         s2_q       <= s1_q;
         s3_q       <= s2_q;
         red_only_q <= red_only;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         cnt_q      <= 5'd0;
         flash_on_q <= 1'b0;
         aborted_q  <= 1'b0;
         req_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         flash_on_q <= flash_on_d;
         aborted_q  <= aborted_d;
         req_q      <= req_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      flash_on_d = flash_on_q;
      aborted_d  = 1'b0;
      req_clear  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (req_q) begin
               state_d = StWaitRed;
            end
         end
         // Only a fresh red edge starts a crossing; a request raised mid-red waits.
         StWaitRed: begin
            if (red_start) begin
               state_d   = StWalk;
               cnt_d     = WalkLoad;
               req_clear = 1'b1;
            end
         end
         StWalk: begin
            if (!red_only) begin
               state_d   = StClear;
               cnt_d     = 5'd0;
               aborted_d = 1'b1;
            end else if (cnt_q == 5'd0) begin
               state_d    = StFlash;
               cnt_d      = FlashLoad;
               flash_on_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 5'd1;
            end
         end
         StFlash: begin
            if (!red_only) begin
               state_d   = StClear;
               cnt_d     = 5'd0;
               aborted_d = 1'b1;
            end else if (cnt_q == 5'd0) begin
               state_d = StClear;
            end else begin
               cnt_d      = cnt_q - 5'd1;
               flash_on_d = ~flash_on_q;
            end
         end
         // Hold until red ends so at most one crossing is served per red phase.
         StClear: begin
            if (!red_only) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = 5'd0;
         end
      endcase
   end

   // A press coinciding with the clear wins.
   always_comb begin
      req_d = req_q;
      if (press) begin
         req_d = 1'b1;
      end else if (req_clear) begin
         req_d = 1'b0;
      end
   end

   always_comb begin
      walk      = 1'b0;
      dont_walk = 1'b1;
      countdown = 5'd0;
      unique case (state_q)
         StWalk: begin
            walk      = 1'b1;
            dont_walk = 1'b0;
         end
         StFlash: begin
            dont_walk = flash_on_q;
            countdown = cnt_q + 5'd1;
         end
         default: begin
         end
      endcase
   end

   assign req_pending = req_q;
   assign aborted     = aborted_q;

endmodule

// File: tb/tb_ped_signal_ctrl.sv
// Self-checking bench for ped_signal_ctrl: per-cycle vector tables fed through a scoreboard,
// plus hand-written glitch and asynchronous-reset sequences.
module tb_ped_signal_ctrl;

   logic       clk;
   logic       reset;
   logic       veh_red;
   logic       veh_yellow;
   logic       veh_green;
   logic       btn;
   logic       walk;
   logic       dont_walk;
   logic       req_pending;
   logic [4:0] countdown;
   logic       aborted;

   ped_signal_ctrl #(
      .WALK_TIME (8),
      .FLASH_TIME(6)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .veh_red    (veh_red),
      .veh_yellow (veh_yellow),
      .veh_green  (veh_green),
      .btn        (btn),
      .walk       (walk),
      .dont_walk  (dont_walk),
      .req_pending(req_pending),
      .countdown  (countdown),
      .aborted    (aborted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Lamp codes as {red, yellow, green}.
   localparam logic [2:0] LG  = 3'b001;
   localparam logic [2:0] LY  = 3'b010;
   localparam logic [2:0] LR  = 3'b100;
   localparam logic [2:0] LRY = 3'b110;
   localparam logic [2:0] LRG = 3'b101;

   typedef struct {
      logic [2:0] lamps;
      logic       b;
      logic       w;
      logic       dw;
      logic [4:0] cd;
      logic       rp;
      logic       ab;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];
   int   total = 0;
   int   bad = 0;

   function automatic void add(logic [2:0] lamps, logic b, logic w, logic dw, logic [4:0] cd,
                               logic rp, logic ab);
      vec_t v;
      v.lamps = lamps;
      v.b     = b;
      v.w     = w;
      v.dw    = dw;
      v.cd    = cd;
      v.rp    = rp;
      v.ab    = ab;
      vecs.push_back(v);
   endfunction

   task automatic check_now(string tag, logic w, logic dw, logic [4:0] cd, logic rp,
                            logic ab);
      total++;
      if (walk !== w || dont_walk !== dw || countdown !== cd || req_pending !== rp ||
          aborted !== ab) begin
         bad++;
         $display("FAIL %s: got w=%b dw=%b cd=%0d rp=%b ab=%b, want w=%b dw=%b cd=%0d rp=%b ab=%b",
                  tag, walk, dont_walk, countdown, req_pending, aborted, w, dw, cd, rp, ab);
      end
   endtask

   task automatic check_sb(string tag, int idx);
      vec_t e;
      if (sb.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s[%0d]: scoreboard empty", tag, idx);
      end else begin
         e = sb.pop_front();
         check_now($sformatf("%s[%0d]", tag, idx), e.w, e.dw, e.cd, e.rp, e.ab);
      end
   endtask

   // Drive each row for one cycle; its expected outputs appear after the next rising edge.
   task automatic run_vecs(string tag);
      for (int i = 0; i < vecs.size(); i++) begin
         {veh_red, veh_yellow, veh_green} = vecs[i].lamps;
         btn = vecs[i].b;
         sb.push_back(vecs[i]);
         @(posedge clk);
         #1;
         check_sb(tag, i);
      end
      vecs.delete();
   endtask

   initial begin
      reset = 1'b1;
      {veh_red, veh_yellow, veh_green} = LG;
      btn = 1'b0;
      #2;
      check_now("reset_state", 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
      #10 reset = 1'b0;
      @(posedge clk);
      #1;

      // Basic crossing: press during green, red held 21 cycles.
      add(LG, 1, 0, 1, 0, 0, 0);
      add(LG, 1, 0, 1, 0, 0, 0);
      add(LG, 0, 0, 1, 0, 1, 0);
      add(LG, 0, 0, 1, 0, 1, 0);
      add(LG, 0, 0, 1, 0, 1, 0);
      for (int i = 0; i < 8; i++) add(LR, 0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) add(LR, 0, 0, ((i % 2) == 0), 5'(6 - i), 0, 0);
      for (int i = 0; i < 7; i++) add(LR, 0, 0, 1, 0, 0, 0);
      add(LG, 0, 0, 1, 0, 0, 0);
      add(LG, 0, 0, 1, 0, 0, 0);
      run_vecs("basic");

      // Late request mid-red, served on next red; then abort 3 cycles into walk.
      for (int i = 0; i < 5; i++) add(LR, 0, 0, 1, 0, 0, 0);
      add(LR, 1, 0, 1, 0, 0, 0);
      add(LR, 0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) add(LR, 0, 0, 1, 0, 1, 0);
      add(LG, 0, 0, 1, 0, 1, 0);
      add(LR, 0, 1, 0, 0, 0, 0);
      add(LR, 0, 1, 0, 0, 0, 0);
      add(LR, 0, 1, 0, 0, 0, 0);
      add(LG, 0, 0, 1, 0, 0, 1);
      add(LG, 0, 0, 1, 0, 0, 0);
      add(LG, 0, 0, 1, 0, 0, 0);
      run_vecs("late_abort");

      // Red+yellow holds off the walk; illegal red+green aborts.
      add(LG, 1, 0, 1, 0, 0, 0);
      add(LG, 0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) add(LRY, 0, 0, 1, 0, 1, 0);
      add(LR, 0, 1, 0, 0, 0, 0);
      add(LR, 0, 1, 0, 0, 0, 0);
      add(LRG, 0, 0, 1, 0, 0, 1);
      add(LG, 0, 0, 1, 0, 0, 0);
      add(LY, 0, 0, 1, 0, 0, 0);
      run_vecs("red_yellow");

      // Sub-period glitch between sampling edges must not register.
      @(posedge clk);
      #2 btn = 1'b1;
      #3 btn = 1'b0;
      for (int i = 0; i < 4; i++) add(LG, 0, 0, 1, 0, 0, 0);
      run_vecs("glitch");

      // Into FLASH with a request latched during walk, then reset between edges.
      add(LG, 1, 0, 1, 0, 0, 0);
      add(LG, 0, 0, 1, 0, 0, 0);
      add(LG, 0, 0, 1, 0, 1, 0);
      add(LG, 0, 0, 1, 0, 1, 0);
      add(LR, 0, 1, 0, 0, 0, 0);
      add(LR, 1, 1, 0, 0, 0, 0);
      add(LR, 0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) add(LR, 0, 1, 0, 0, 1, 0);
      add(LR, 0, 0, 1, 6, 1, 0);
      add(LR, 0, 0, 0, 5, 1, 0);
      run_vecs("pre_reset");
      #3 reset = 1'b1;
      #1;
      check_now("async_reset", 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
      @(posedge clk);
      #2 reset = 1'b0;
      for (int i = 0; i < 4; i++) add(LR, 0, 0, 1, 0, 0, 0);
      add(LG, 0, 0, 1, 0, 0, 0);
      add(LG, 0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) add(LR, 0, 0, 1, 0, 0, 0);
      run_vecs("post_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

endmodule
